// File: rtl/pixel_writer_if.sv
// Pixel writer bus bundle: pixel source strobe, memory write channel and
// status outputs. The clock and reset are not part of this bundle.
//   slave  : the pixel_writer side (consumes pixels, drives memory/status)
//   master : the environment side (pixel source + memory + status reader)
interface pixel_writer_if #(
  parameter int P_X_COORD_W = 11,
  parameter int P_Y_COORD_W = 11,
  parameter int P_ADDR_W    = 19,
  parameter int P_COLOR_W   = 8
);
  logic [P_X_COORD_W-1:0] i_x_val;
  logic [P_Y_COORD_W-1:0] i_y_val;
  logic                   i_vals_rdy;
  logic [P_COLOR_W-1:0]   i_color;
  logic                   i_mem_ack;
  logic                   i_clr_status;
  logic                   o_mem_wr_req;
  logic [P_ADDR_W-1:0]    o_mem_addr;
  logic [P_COLOR_W-1:0]   o_mem_data;
  logic                   o_busy;
  logic                   o_overflow;
  logic [15:0]            o_pix_cnt;
  logic [15:0]            o_clip_cnt;

  modport slave (
    input  i_x_val, i_y_val, i_vals_rdy, i_color, i_mem_ack, i_clr_status,
    output o_mem_wr_req, o_mem_addr, o_mem_data, o_busy, o_overflow,
           o_pix_cnt, o_clip_cnt
  );

  modport master (
    output i_x_val, i_y_val, i_vals_rdy, i_color, i_mem_ack, i_clr_status,
    input  o_mem_wr_req, o_mem_addr, o_mem_data, o_busy, o_overflow,
           o_pix_cnt, o_clip_cnt
  );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer: buffers strobed {x,y,color} pixels in a small FIFO, clips
// them against the framebuffer, and issues one memory write per visible
// pixel (address = y*P_FB_WIDTH + x) with a req/ack handshake.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : pixel_writer_if.slave -- pixel input, memory write channel,
//             o_busy / o_overflow / o_pix_cnt / o_clip_cnt status
module pixel_writer #(
  parameter int P_X_COORD_W  = 11,
  parameter int P_Y_COORD_W  = 11,
  parameter int P_FB_WIDTH   = 640,
  parameter int P_FB_HEIGHT  = 480,
  parameter int P_ADDR_W     = 19,
  parameter int P_COLOR_W    = 8,
  parameter int P_FIFO_DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  pixel_writer_if.slave bus
);

  localparam int PW   = $clog2(P_FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  // Wide enough that y*width+x never overflows before truncation.
  localparam int MW   = P_Y_COORD_W + 32;
  localparam logic [CNTW-1:0] FULL = CNTW'(P_FIFO_DEPTH);
  localparam logic [31:0]     FB_W = 32'(P_FB_WIDTH);
  localparam logic [31:0]     FB_H = 32'(P_FB_HEIGHT);

  typedef struct packed {
    logic [P_X_COORD_W-1:0] x;
    logic [P_Y_COORD_W-1:0] y;
    logic [P_COLOR_W-1:0]   c;
  } pix_t;

  typedef enum logic [1:0] {IDLE, ADDR, REQ} state_t;

  state_t          state_q, state_d;
  pix_t            fifo_q [P_FIFO_DEPTH];
  pix_t            fifo_d [P_FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  pix_t            work_q, work_d;
  logic            req_q, req_d;
  logic [P_ADDR_W-1:0]  addr_q, addr_d;
  logic [P_COLOR_W-1:0] data_q, data_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     pix_q, pix_d, clip_q, clip_d;
  logic            pop, push, pix_inc, clip_inc, clipped;

  // FSM: IDLE pops the head into the working registers, ADDR clips or
  // forms the request, REQ holds the request until acked.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pop      = 1'b0;
    pix_inc  = 1'b0;
    clip_inc = 1'b0;
    clipped  = (32'(work_q.x) >= FB_W) || (32'(work_q.y) >= FB_H);
    unique case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        work_d  = fifo_q[rptr_q];
        state_d = ADDR;
      end
      ADDR: if (clipped) begin
        clip_inc = 1'b1;
        state_d  = IDLE;
      end else begin
        addr_d  = P_ADDR_W'(MW'(work_q.y) * MW'(P_FB_WIDTH) + MW'(work_q.x));
        data_d  = work_q.c;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.i_mem_ack) begin
        req_d   = 1'b0;
        pix_inc = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees a slot, so a full FIFO still
  // accepts a strobe when the FSM is draining it.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    push   = bus.i_vals_rdy && ((cnt_q != FULL) || pop);
    if (push) begin
      fifo_d[wptr_q] = {bus.i_x_val, bus.i_y_val, bus.i_color};
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
  end

  // Status: clear beats any same-cycle increment or overflow set.
  always_comb begin
    ovf_d  = ovf_q | (bus.i_vals_rdy & ~push);
    pix_d  = pix_q;
    clip_d = clip_q;
    if (pix_inc && pix_q != 16'hFFFF)   pix_d  = pix_q + 16'd1;
    if (clip_inc && clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
    if (bus.i_clr_status) begin
      ovf_d  = 1'b0;
      pix_d  = '0;
      clip_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      for (int i = 0; i < P_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      pix_q   <= '0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      pix_q   <= pix_d;
      clip_q  <= clip_d;
    end
  end

  assign bus.o_mem_wr_req = req_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_data   = data_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_pix_cnt    = pix_q;
  assign bus.o_clip_cnt   = clip_q;
  assign bus.o_busy       = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer. A queue of expected pixels (in strobe
// order) is the reference: every completed memory write must match the next
// visible pixel, clipped pixels are skipped and counted, and status counters
// are compared against the model's tallies.
module tb_pixel_writer;
  localparam int XW = 11, YW = 11, FBW = 640, FBH = 480;
  localparam int AW = 19, CW = 8, DEPTH = 8;

  typedef struct { int x; int y; int c; } pix_t;

  logic clk = 1'b0;
  logic rst;
  logic ack_set = 1'b0, ack_r = 1'b0, ack_rand = 1'b0;
  bit   mon_en = 1'b0;
  int   n_chk = 0, n_err = 0;
  pix_t exp_q[$];
  int   exp_pix = 0, exp_clip = 0, writes = 0, w0;
  logic held_v = 1'b0;
  logic [AW-1:0] held_addr;
  logic [CW-1:0] held_data;

  always #5 clk = ~clk;

  pixel_writer_if #(.P_X_COORD_W(XW), .P_Y_COORD_W(YW),
                    .P_ADDR_W(AW), .P_COLOR_W(CW)) bus ();

  pixel_writer #(.P_X_COORD_W(XW), .P_Y_COORD_W(YW), .P_FB_WIDTH(FBW),
                 .P_FB_HEIGHT(FBH), .P_ADDR_W(AW), .P_COLOR_W(CW),
                 .P_FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));

  assign bus.i_mem_ack = ack_rand ? ack_r : ack_set;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit is_clip(input pix_t p);
    return (p.x >= FBW) || (p.y >= FBH);
  endfunction

  function automatic int addr_of(input pix_t p);
    return p.y * FBW + p.x;
  endfunction

  // Scoreboard, sampled at the falling edge.
  task automatic monitor();
    pix_t p;
    if (mon_en && bus.o_mem_wr_req) begin
      if (held_v) begin
        chk("hold_addr", 32'(bus.o_mem_addr), 32'(held_addr));
        chk("hold_data", 32'(bus.o_mem_data), 32'(held_data));
      end
      if (bus.i_mem_ack) begin
        while (exp_q.size() > 0 && is_clip(exp_q[0])) void'(exp_q.pop_front());
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          chk("wr_addr", 32'(bus.o_mem_addr), 32'(addr_of(p)));
          chk("wr_data", 32'(bus.o_mem_data), 32'(p.c));
        end
        writes++;
        if (exp_pix < 65535) exp_pix++;
        held_v = 1'b0;
      end else begin
        held_v    = 1'b1;
        held_addr = bus.o_mem_addr;
        held_data = bus.o_mem_data;
      end
    end else begin
      held_v = 1'b0;
    end
  endtask

  // Advance one cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    ack_r = ($urandom_range(0, 2) == 0);
  endtask

  task automatic strobe(input int x, input int y, input int c, input bit acc);
    pix_t p;
    bus.i_vals_rdy = 1'b1;
    bus.i_x_val    = XW'(x);
    bus.i_y_val    = YW'(y);
    bus.i_color    = CW'(c);
    if (acc) begin
      p = '{x, y, c};
      exp_q.push_back(p);
      if (is_clip(p) && exp_clip < 65535) exp_clip++;
    end
    tick();
    bus.i_vals_rdy = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin tick(); n++; end
    chk("wait_idle", 32'(bus.o_busy), 0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bus.o_mem_wr_req && n < budget) begin tick(); n++; end
    chk("wait_req", 32'(bus.o_mem_wr_req), 1);
  endtask

  // With the DUT idle, anything left in the model must be clipped pixels.
  task automatic drain_clipped();
    while (exp_q.size() > 0 && is_clip(exp_q[0])) void'(exp_q.pop_front());
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_counts(input string tag, input logic ovf);
    chk({tag, "_pix"},  32'(bus.o_pix_cnt),  32'(exp_pix));
    chk({tag, "_clip"}, 32'(bus.o_clip_cnt), 32'(exp_clip));
    chk({tag, "_ovf"},  32'(bus.o_overflow), 32'(ovf));
  endtask

  task automatic clear_status();
    bus.i_clr_status = 1'b1;
    tick();
    bus.i_clr_status = 1'b0;
    exp_pix  = 0;
    exp_clip = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_vals_rdy = 1'b1;  // strobes under reset must be ignored
    bus.i_x_val = 11'd5; bus.i_y_val = 11'd5; bus.i_color = 8'd33;
    bus.i_clr_status = 1'b0;
    @(posedge clk); #1;
    repeat (4) tick();
    rst = 1'b0;
    bus.i_vals_rdy = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_req",  32'(bus.o_mem_wr_req), 0);
    chk("rst_addr", 32'(bus.o_mem_addr), 0);
    chk("rst_data", 32'(bus.o_mem_data), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk_counts("rst", 1'b0);
    tick();
    chk("rst_strobe_ignored", 32'(bus.o_busy), 0);

    // Single pixel latency: request in cycle N+3
    ack_set = 1'b1;
    strobe(10, 2, 8'h5A, 1'b1);
    chk("lat_n1", 32'(bus.o_mem_wr_req), 0);
    tick();
    chk("lat_n2", 32'(bus.o_mem_wr_req), 0);
    tick();
    chk("lat_n3_req",  32'(bus.o_mem_wr_req), 1);
    chk("lat_n3_addr", 32'(bus.o_mem_addr), 1290);
    chk("lat_n3_data", 32'(bus.o_mem_data), 32'h5A);
    tick();
    chk("lat_req_drop", 32'(bus.o_mem_wr_req), 0);
    chk("lat_pix", 32'(bus.o_pix_cnt), 1);
    tick();
    chk("lat_busy", 32'(bus.o_busy), 0);

    // Last visible pixel, then one just off the right edge
    w0 = writes;
    strobe(639, 479, 8'hC3, 1'b1);
    strobe(640, 0, 8'h11, 1'b1);
    wait_idle(100);
    chk("edge_writes", 32'(writes - w0), 1);
    chk("edge_clip", 32'(bus.o_clip_cnt), 1);
    chk_counts("edge", 1'b0);

    clear_status();
    chk_counts("clr", 1'b0);

    // Slow ack: request held stable five cycles
    ack_set = 1'b0;
    strobe(100, 200, 8'h77, 1'b1);
    wait_req(20);
    repeat (5) tick();
    chk("slow_req_held", 32'(bus.o_mem_wr_req), 1);
    ack_set = 1'b1;
    tick();
    chk("slow_req_drop", 32'(bus.o_mem_wr_req), 0);
    chk("slow_pix", 32'(bus.o_pix_cnt), 32'(exp_pix));
    ack_set = 1'b0;

    // Overflow: 12 back-to-back strobes with memory stalled; 1 in the
    // working registers plus DEPTH in the FIFO are kept.
    clear_status();
    for (int i = 0; i < 12; i++) strobe(i * 7, i + 1, i + 16, i <= DEPTH);
    tick();
    chk("ovf_flag", 32'(bus.o_overflow), 1);
    chk("ovf_req",  32'(bus.o_mem_wr_req), 1);
    chk("ovf_busy", 32'(bus.o_busy), 1);
    w0 = writes;
    ack_set = 1'b1;
    wait_idle(200);
    chk("ovf_writes", 32'(writes - w0), 9);
    chk("ovf_pix9", 32'(bus.o_pix_cnt), 9);
    chk_counts("ovf", 1'b1);

    // Clear coincident with ack
    ack_set = 1'b0;
    strobe(1, 1, 8'h22, 1'b1);
    wait_req(20);
    ack_set = 1'b1;
    bus.i_clr_status = 1'b1;
    tick();
    bus.i_clr_status = 1'b0;
    ack_set = 1'b0;
    exp_pix = 0;
    exp_clip = 0;
    chk("clrack_req", 32'(bus.o_mem_wr_req), 0);
    chk_counts("clrack", 1'b0);

    // Random traffic with random ack; strobes paced so none overflow
    ack_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!bus.o_busy) drain_clipped();
      if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1)
        strobe(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
               int'($urandom_range(0, 255)), 1'b1);
      else
        tick();
    end
    ack_rand = 1'b0;
    ack_set  = 1'b1;
    wait_idle(300);
    drain_clipped();
    chk_counts("rand", 1'b0);

    // Reset in the middle of a request with 4 pixels queued
    ack_set = 1'b0;
    for (int i = 0; i < 5; i++) strobe(20 + i, 30, 40 + i, 1'b1);
    wait_req(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_pix = 0;
    exp_clip = 0;
    chk("mrst_req",  32'(bus.o_mem_wr_req), 0);
    chk("mrst_busy", 32'(bus.o_busy), 0);
    chk_counts("mrst", 1'b0);
    ack_set = 1'b1;
    w0 = writes;
    repeat (30) tick();
    chk("mrst_no_writes", 32'(writes - w0), 0);
    chk("mrst_busy_after", 32'(bus.o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameters: P_X_COORD_W, 11, x width; P_Y_COORD_W, 11, y width; P_FB_WIDTH, 640, framebuffer columns; P_FB_HEIGHT, 480, framebuffer rows; P_ADDR_W, 19, memory address width; P_COLOR_W, 8, pixel data width; P_FIFO_DEPTH, 8, pixel FIFO entries (power of 2).
REQ-002 SHALL have ports: i_clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-003 i_reset  in  1  reset; synchronous, active-high.
REQ-004 i_x_val  in  P_X_COORD_W  pixel x, unsigned.
REQ-005 i_y_val  in  P_Y_COORD_W  pixel y, unsigned.
REQ-006 i_vals_rdy  in  1  one-cycle pixel strobe; no backpressure to source.
REQ-007 i_color  in  P_COLOR_W  colour, sampled with i_vals_rdy.
REQ-008 i_mem_ack  in  1  memory write accept.
REQ-009 i_clr_status  in  1  clears o_overflow, o_pix_cnt, o_clip_cnt.
REQ-010 o_mem_wr_req  out  1  write request.
REQ-011 o_mem_addr  out  P_ADDR_W  write address.
REQ-012 o_mem_data  out  P_COLOR_W  write data.
REQ-013 o_busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-014 o_overflow  out  1  sticky: pixel dropped on full FIFO.
REQ-015 o_pix_cnt  out  16  pixels written, saturating at 16'hFFFF.
REQ-016 o_clip_cnt  out  16  pixels discarded by clipping, saturating.

Function
REQ-017 FIFO SHALL push {x,y,color} on any edge where i_vals_rdy=1 and count<P_FIFO_DEPTH.
REQ-018 Push with count==P_FIFO_DEPTH (and no pop that cycle) SHALL drop pixel, set o_overflow; FIFO contents unchanged.
REQ-019 Push and pop on same edge SHALL both occur; count unchanged; at full with pop, push accepted.
REQ-020 FSM states: IDLE, ADDR, REQ; all registered outputs.
REQ-021 IDLE: if FIFO non-empty, pop head into working registers, go ADDR; else stay.
REQ-022 ADDR: if x>=P_FB_WIDTH or y>=P_FB_HEIGHT, increment o_clip_cnt, go IDLE, no request; else load o_mem_addr=y*P_FB_WIDTH+x (truncated to P_ADDR_W), o_mem_data=color, set o_mem_wr_req=1, go REQ.
REQ-023 REQ: hold o_mem_wr_req, o_mem_addr, o_mem_data stable until edge where i_mem_ack=1; on that edge clear o_mem_wr_req, increment o_pix_cnt, go IDLE.
REQ-024 i_mem_ack outside REQ SHALL be ignored.
REQ-025 Latency: i_vals_rdy in cycle N into empty FIFO, FSM IDLE -> o_mem_wr_req high in cycle N+3.
REQ-026 Throughput with i_mem_ack tied high: one write per 3 cycles; FIFO order preserved (FIFO out = strobe order).
REQ-027 Read/write pointers SHALL wrap modulo P_FIFO_DEPTH; count held separately, 0..P_FIFO_DEPTH.
REQ-028 i_clr_status SHALL zero o_overflow, o_pix_cnt, o_clip_cnt next edge; clear wins over simultaneous increment/set.
REQ-029 Counters SHALL saturate, not wrap.
REQ-030 o_busy SHALL be combinational: (count!=0) or (state!=IDLE).

Reset
REQ-031 On i_reset: state IDLE, FIFO empty, pointers 0, o_mem_wr_req=0, o_mem_addr=0, o_mem_data=0, o_overflow=0, o_pix_cnt=0, o_clip_cnt=0.
REQ-032 Reset during REQ SHALL drop o_mem_wr_req next edge; pending pixel and FIFO contents discarded; no count increment.
REQ-033 i_vals_rdy during reset SHALL be ignored.

Verification
REQ-034 Single pixel x=10,y=2,color=8'h5A, ack tied 1 -> req high N+3, addr=1290, data=8'h5A, o_pix_cnt=1, o_busy low after.
REQ-035 Pixels (639,479) and (640,0) -> first addr=307199 written; second discarded, o_clip_cnt=1, no request.
REQ-036 12 consecutive strobes, ack held 0 -> 9 accepted (1 in working regs + 8 FIFO), o_overflow=1; release ack -> 9 writes in strobe order, o_pix_cnt=9.
REQ-037 Ack delayed 5 cycles -> addr/data/req stable throughout; deassert one edge after ack.
REQ-038 Reset asserted mid-REQ with 4 in FIFO -> req low next cycle, o_busy=0, counters 0, no further writes.
REQ-039 i_clr_status coincident with ack -> o_pix_cnt=0 after edge, o_overflow=0.
